conv3x3_multi_ch: RTL

//  Streaming 3x3 convolution over CIN input channels with runtime-loadable weights and bias.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_mac9.sv | 64 ++++++
 rtl/conv3x3_multi_ch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types, width helpers and fixed-point round/saturate helpers for the conv blocks.
package conv_pkg;

  typedef enum logic {CFG, RUN} state_t;

  localparam int DATA_W_DEF = 8;
  localparam int FRAC_DEF   = 4;
  localparam int CIN_DEF    = 3;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int sum_w(input int dw);
    return 2 * dw + 4;
  endfunction

  function automatic int acc_w(input int dw, input int cin);
    return 2 * dw + 4 + $clog2(cin + 1);
  endfunction

  localparam int PROD_W = prod_w(DATA_W_DEF);
  localparam int SUM_W  = sum_w(DATA_W_DEF);
  localparam int ACC_W  = acc_w(DATA_W_DEF, CIN_DEF);

  // Round half up, then drop the fractional bits (arithmetic shift floors negatives).
  function automatic logic signed [63:0] round_q(input logic signed [63:0] v, input int frac);
    return (v + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_q(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// Nine signed multipliers (S1) feeding a registered adder tree (S2); channel tags ride along.
module conv_mac9
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             in_fire,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic signed [DATA_W-1:0]         taps [9],
  input  logic signed [DATA_W-1:0]         wts  [9],
  output logic                             busy,
  output logic                             sum_valid,
  output logic                             sum_first,
  output logic                             sum_last,
  output logic signed [sum_w(DATA_W)-1:0]  sum
);

  localparam int PW = prod_w(DATA_W);
  localparam int SW = sum_w(DATA_W);

  logic signed [PW-1:0] prod [9];
  logic                 v1, f1, l1;
  logic signed [SW-1:0] tree;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      for (int k = 0; k < 9; k++) prod[k] <= '0;
    end else if (en) begin
      v1 <= in_fire;
      f1 <= in_first;
      l1 <= in_last;
      for (int k = 0; k < 9; k++) prod[k] <= PW'(taps[k]) * PW'(wts[k]);
    end
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < 9; k++) tree = tree + SW'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid <= 1'b0;
      sum_first <= 1'b0;
      sum_last  <= 1'b0;
      sum       <= '0;
    end else if (en) begin
      sum_valid <= v1;
      sum_first <= f1;
      sum_last  <= l1;
      sum       <= tree;
    end
  end

  assign busy = v1 || sum_valid;

endmodule

// File: rtl/conv3x3_multi_ch.sv
// Channel-serial 3x3 convolution with runtime weights/bias, rounding and saturation.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv3x3_multi_ch
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int CIN    = CIN_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [$clog2(9*CIN+1)-1:0]         cfg_addr,
  input  logic signed [DATA_W-1:0]           cfg_wdata,
  input  logic                               cfg_go,
  input  logic                               cfg_stop,
  output logic                               running,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [DATA_W-1:0]           p00, p01, p02,
  input  logic signed [DATA_W-1:0]           p10, p11, p12,
  input  logic signed [DATA_W-1:0]           p20, p21, p22,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DATA_W-1:0]           out_data
);

  localparam int AW  = $clog2(9 * CIN + 1);
  localparam int CW  = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int SW  = sum_w(DATA_W);
  localparam int ACW = acc_w(DATA_W, CIN);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(9 * CIN);
  localparam logic [CW-1:0] LAST_CH   = CW'(CIN - 1);

  state_t                   state, state_nx;
  logic signed [DATA_W-1:0] w_rf [CIN][9];
  logic signed [DATA_W-1:0] bias;
  logic signed [DATA_W-1:0] ch_w [9];
  logic signed [DATA_W-1:0] taps [9];
  logic [CW-1:0]            ch_cnt;
  logic                     stop_pend, stall, accept, mac_busy;
  logic                     s2_valid, s2_first, s2_last;
  logic signed [SW-1:0]     s2_sum;
  logic                     s3_valid, s3_last;
  logic signed [ACW-1:0]    acc;
  logic                     s4_valid;
  logic signed [DATA_W-1:0] s4_data, res;

  assign stall  = out_valid && !out_ready;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    running  = 1'b0;
    case (state)
      CFG: if (cfg_go) state_nx = RUN;
      RUN: begin
        running  = 1'b1;
        in_ready = !stall && !(stop_pend && ch_cnt == '0);
        if (stop_pend && ch_cnt == '0 && !mac_busy && !s3_valid && !s4_valid && !out_valid)
          state_nx = CFG;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CFG;
      stop_pend <= 1'b0;
      ch_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && state_nx == CFG) stop_pend <= 1'b0;
      else if (state == RUN && cfg_stop)   stop_pend <= 1'b1;
      if (accept) ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
    end
  end

  // Weights and bias only change in CFG, so the pipeline can read them freely in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CIN; c++)
        for (int k = 0; k < 9; k++) w_rf[c][k] <= '0;
      bias <= '0;
    end else if (state == CFG && cfg_we) begin
      for (int c = 0; c < CIN; c++)
        for (int k = 0; k < 9; k++)
          if (cfg_addr == AW'(c * 9 + k)) w_rf[c][k] <= cfg_wdata;
      if (cfg_addr == BIAS_ADDR) bias <= cfg_wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) ch_w[k] = w_rf[ch_cnt][k];
    taps[0] = p00; taps[1] = p01; taps[2] = p02;
    taps[3] = p10; taps[4] = p11; taps[5] = p12;
    taps[6] = p20; taps[7] = p21; taps[8] = p22;
  end

  conv_mac9 #(.DATA_W(DATA_W)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en        (!stall),
    .in_fire   (accept),
    .in_first  (ch_cnt == '0),
    .in_last   (ch_cnt == LAST_CH),
    .taps      (taps),
    .wts       (ch_w),
    .busy      (mac_busy),
    .sum_valid (s2_valid),
    .sum_first (s2_first),
    .sum_last  (s2_last),
    .sum       (s2_sum)
  );

  always_comb begin
    logic signed [63:0] r;
    r = sat_q(round_q(64'(acc), FRAC), DATA_W);
`ifdef CONV_RELU_EN
    if (r < 0) r = '0;
`endif
    res = DATA_W'(r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid  <= 1'b0;
      s3_last   <= 1'b0;
      acc       <= '0;
      s4_valid  <= 1'b0;
      s4_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      if (s2_valid) acc <= (s2_first ? (ACW'(bias) <<< FRAC) : acc) + ACW'(s2_sum);
      s4_valid <= s3_valid && s3_last;
      if (s3_valid && s3_last) s4_data <= res;
      out_valid <= s4_valid;
      if (s4_valid) out_data <= s4_data;
    end
  end

endmodule
